// File: rtl/wb_regfile.sv
// Writeback stage: load extraction, writeback mux, 32-entry register file with bypassed reads, commit trace.
// Latency: read ports combinational (write-through bypass); commit trace and retire count 1 cycle after WB.
// Backpressure: none; every valid WB slot retires, upstream inserts bubbles on stall/flush.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_insn_vld,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus4,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_lsu_data,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_rd_wren,
    input  logic [1:0]      i_wb_sel,
    input  logic            i_data_sel,
    input  logic [1:0]      i_extend_data_sel,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_commit_vld,
    output logic [XLEN-1:0] o_commit_pc,
    output logic [4:0]      o_commit_rd,
    output logic [XLEN-1:0] o_commit_data,
    output logic [31:0]     o_retire_cnt
);

    logic [XLEN-1:0] regs [NREGS];
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            ld_sign;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wb_data;
    logic            we;
    logic [31:0]     retire_cnt;

    // Pick the addressed byte/half from the aligned load word and extend it.
    // A half access only looks at offset bit 1; odd offsets are not trapped here.
    always_comb begin
        ld_byte = i_lsu_data[7:0];
        case (i_alu_result[1:0])
            2'd0:    ld_byte = i_lsu_data[7:0];
            2'd1:    ld_byte = i_lsu_data[15:8];
            2'd2:    ld_byte = i_lsu_data[23:16];
            default: ld_byte = i_lsu_data[31:24];
        endcase
        ld_half = i_alu_result[1] ? i_lsu_data[31:16] : i_lsu_data[15:0];
        ld_sign = 1'b0;
        ld_data = i_lsu_data;
        case (i_extend_data_sel)
            2'b00: begin
                ld_sign = ~i_data_sel & ld_byte[7];
                ld_data = {{(XLEN-8){ld_sign}}, ld_byte};
            end
            2'b01: begin
                ld_sign = ~i_data_sel & ld_half[15];
                ld_data = {{(XLEN-16){ld_sign}}, ld_half};
            end
            default: ld_data = i_lsu_data;
        endcase
    end

    // Writeback source select; the unused encoding yields zero.
    always_comb begin
        wb_data = '0;
        case (i_wb_sel)
            2'b00:   wb_data = i_pc_plus4;
            2'b01:   wb_data = i_alu_result;
            2'b10:   wb_data = ld_data;
            default: wb_data = '0;
        endcase
    end

    // A write only happens for a real instruction targeting a non-zero register.
    assign we = i_insn_vld & i_rd_wren & (i_rd_addr != 5'd0);

    // Read ports: x0 reads zero, a same-cycle write to the read address is forwarded.
    always_comb begin
        if (i_rs1_addr == 5'd0)
            o_rs1_data = '0;
        else if (we && (i_rs1_addr == i_rd_addr))
            o_rs1_data = wb_data;
        else
            o_rs1_data = regs[i_rs1_addr];

        if (i_rs2_addr == 5'd0)
            o_rs2_data = '0;
        else if (we && (i_rs2_addr == i_rd_addr))
            o_rs2_data = wb_data;
        else
            o_rs2_data = regs[i_rs2_addr];
    end

    // Register file storage; reset overrides a write presented in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[i_rd_addr] <= wb_data;
        end
    end

    // Commit trace: one-cycle delayed record of what the WB slot did.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_commit_vld  <= 1'b0;
            o_commit_pc   <= '0;
            o_commit_rd   <= 5'd0;
            o_commit_data <= '0;
        end else begin
            o_commit_vld  <= i_insn_vld;
            o_commit_pc   <= i_pc;
            o_commit_rd   <= we ? i_rd_addr : 5'd0;
            o_commit_data <= we ? wb_data : '0;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            retire_cnt <= 32'd0;
        else if (i_insn_vld)
            retire_cnt <= retire_cnt + 32'd1;
    end

    assign o_retire_cnt = retire_cnt;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (PC+4, ALU result, or extended load data) and performs load byte/half extraction with sign/zero extension.
- Writes the 32-entry integer register file and provides two combinational read ports to decode, with write-through bypass.
- Emits a registered commit trace and a retired-instruction counter for debug.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_insn_vld  in  1  WB slot holds a real instruction (0 = bubble)
- i_pc  in  XLEN  PC of the WB instruction
- i_pc_plus4  in  XLEN  PC+4 of the WB instruction
- i_alu_result  in  XLEN  ALU result; bits [1:0] give the load byte offset
- i_lsu_data  in  XLEN  raw aligned 32-bit load word
- i_rd_addr  in  5  destination register
- i_rd_wren  in  1  destination write enable
- i_wb_sel  in  2  00 = PC+4, 01 = ALU, 10 = load, 11 = zero
- i_data_sel  in  1  load extension: 0 = sign, 1 = zero
- i_extend_data_sel  in  2  load size: 00 = byte, 01 = half, 10/11 = word
- i_rs1_addr  in  5  read port 1 address
- i_rs2_addr  in  5  read port 2 address
- o_rs1_data  out  XLEN  read port 1 data (combinational)
- o_rs2_data  out  XLEN  read port 2 data (combinational)
- o_commit_vld  out  1  registered: an instruction retired last cycle
- o_commit_pc  out  XLEN  registered PC of the retired instruction
- o_commit_rd  out  5  registered rd (0 if no write)
- o_commit_data  out  XLEN  registered writeback value (0 if no write)
- o_retire_cnt  out  32  retired-instruction count

Behaviour:
- Load extraction (combinational):
  - Byte lane = i_alu_result[1:0]; lane 0 = bits [7:0].
  - Half lane = i_alu_result[1]; i_alu_result[0] is ignored, with no misalign trap.
  - Word passes the raw load word unchanged.
  - Extension to XLEN: sign if i_data_sel = 0, zero if i_data_sel = 1.
- Writeback value: wb_data is selected by i_wb_sel; encoding 11 yields 0.
- Effective write enable: we = i_insn_vld & i_rd_wren & (i_rd_addr != 0).
- Write:
  - When we is high, regs[i_rd_addr] <= wb_data at the rising edge.
  - Writes to x0 are dropped; reading x0 always returns 0.
- Read ports:
  - Combinational from regs.
  - Bypass: if we and rsN_addr == i_rd_addr, o_rsN_data = wb_data in the same cycle.
  - Both ports may bypass simultaneously.
- Commit trace, updated at each rising edge:
  - o_commit_vld <= i_insn_vld.
  - o_commit_pc <= i_pc.
  - o_commit_rd <= we ? i_rd_addr : 0.
  - o_commit_data <= we ? wb_data : 0.
  - Latency is 1 cycle after the WB cycle.
- Retire counter:
  - Increments by 1 on each cycle with i_insn_vld = 1.
  - Wraps 0xFFFF_FFFF -> 0.
- Reset (synchronous, i_rst = 1 at an edge):
  - All registers x1..x31 become 0.
  - o_commit_vld, o_commit_pc, o_commit_rd, o_commit_data and o_retire_cnt become 0.
  - A write presented in the same cycle as reset is discarded; reset wins.
  - Combinational reads during the reset cycle still show pre-reset contents plus bypass.
- Bubbles: i_insn_vld = 0 suppresses the write, holds the counter, and gives o_commit_vld = 0 next cycle, regardless of i_rd_wren.
- No stall input: each cycle with i_insn_vld = 1 counts as one retirement. The upstream register delivers a bubble on stall/flush.

Test Plan:
- Reset, then read all 32 addresses.
  - Expect all reads 0, o_retire_cnt = 0, o_commit_vld = 0.
- ALU write: vld = 1, wren = 1, rd = 5, wb_sel = 01, alu = 0x1234_5678, rs1 = 5 in the same cycle.
  - Expect o_rs1_data = 0x1234_5678 via bypass.
  - Next cycle: read without bypass returns the same value; commit_rd = 5, commit_data = 0x1234_5678.
- LB with lsu = 0x80FF_7F01 at offsets 0..3 (sign), then LBU and LHU.
  - LB returns 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80.
  - LBU at offset 3 returns 0x80.
  - LHU at offset 2 returns 0x80FF.
- rd = 0 write with alu = 0xDEAD_BEEF, rs1 = rs2 = 0.
  - Expect reads 0, commit_rd = 0, commit_data = 0.
  - The counter still increments.
- Bubble vs. reset:
  - vld = 0 with wren = 1 to rd = 7: x7 is unchanged, the counter holds.
  - Write to x9 asserted together with i_rst: x9 = 0 afterward.
- Counter wrap: force o_retire_cnt to 0xFFFF_FFFF, present one valid instruction.
  - Expect the counter to read 0.
- JAL-style writeback: wb_sel = 00, pc_plus4 = 0x0000_0104, rd = 1.
  - Expect x1 = 0x104 and commit_pc = i_pc.
